// File: rtl/mcrc_pkg.sv
// Shared types and helpers for the multicore run controller.
// State encoding and 32-bit lane packing of per-core buses.
package mcrc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int unsigned LANE_W = 32;

    function automatic int unsigned lane_lsb(input int unsigned idx);
        return LANE_W * idx;
    endfunction

endpackage

// File: rtl/core_stop_monitor.sv
// Per-core watcher of the data-memory write port.
// Flags the stop token and keeps a saturating write count.
module core_stop_monitor
    import mcrc_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] STOP_ADDR = 32'h0000_00FC,
    parameter logic [31:0] STOP_DATA = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memwrite_i,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      data_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             stop_hit_o,
    output logic             done_o,
    output logic [CNT_W-1:0] wr_count_o
);

    logic             done_q, done_d;
    logic [CNT_W-1:0] wr_q, wr_d;

    assign stop_hit_o = enable_i && memwrite_i &&
                        (adr_i == STOP_ADDR) &&
                        (data_i == STOP_DATA);

    // Next-state: clear on a new run, count and latch only while enabled.
    always_comb begin
        done_d = done_q;
        wr_d   = wr_q;
        if (clear_i) begin
            done_d = 1'b0;
            wr_d   = '0;
        end else if (enable_i) begin
            if (memwrite_i && (wr_q != {CNT_W{1'b1}})) begin
                wr_d = wr_q + 1'b1;
            end
            if (stop_hit_o) begin
                done_d = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q <= 1'b0;
            wr_q   <= '0;
        end else begin
            done_q <= done_d;
            wr_q   <= wr_d;
        end
    end

    assign done_o     = done_q;
    assign wr_count_o = wr_q;

endmodule

// File: rtl/multicore_run_ctrl.sv
// Run controller: sequences core reset, bounds the run,
// and reports completion via per-core stop-token monitors.
module multicore_run_ctrl
    import mcrc_pkg::*;
#(
    parameter int unsigned NCORES     = 2,
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned MAX_CYCLES = 15,
    parameter int unsigned CNT_W      = 16,
    parameter logic [31:0] STOP_ADDR  = 32'h0000_00FC,
    parameter logic [31:0] STOP_DATA  = 32'h0000_0001
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NCORES-1:0]         core_memwrite,
    input  logic [32*NCORES-1:0]      core_dataadr,
    input  logic [32*NCORES-1:0]      core_writedata,
    output logic                      core_rst,
    output logic                      running,
    output logic                      done,
    output logic                      timeout,
    output logic [NCORES-1:0]         done_mask,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W*NCORES-1:0]   wr_count
);

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              clear_w;
    logic              run_w;
    logic [NCORES-1:0] hit_w;
    logic [NCORES-1:0] mask_w;
    logic [NCORES-1:0] mask_nxt;

    assign run_w    = (state_q == ST_RUN);
    assign mask_nxt = mask_w | hit_w;

    for (genvar g = 0; g < NCORES; g++) begin : g_mon
        core_stop_monitor #(
            .CNT_W     (CNT_W),
            .STOP_ADDR (STOP_ADDR),
            .STOP_DATA (STOP_DATA)
        ) u_mon (
            .clk        (clk),
            .rst        (rst),
            .memwrite_i (core_memwrite[g]),
            .adr_i      (core_dataadr[lane_lsb(g) +: LANE_W]),
            .data_i     (core_writedata[lane_lsb(g) +: LANE_W]),
            .enable_i   (run_w),
            .clear_i    (clear_w),
            .stop_hit_o (hit_w[g]),
            .done_o     (mask_w[g]),
            .wr_count_o (wr_count[g*CNT_W +: CNT_W])
        );
    end

    // Next-state and flag logic; the last stop hit beats budget expiry.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        cyc_d     = cyc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        clear_w   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rcnt_d    = '0;
                    cyc_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    clear_w   = 1'b1;
                end
            end
            ST_RESET: begin
                if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (&mask_nxt) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (cyc_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state, counters and outputs derived from next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            cyc_q      <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            cyc_q      <= cyc_d;
            core_rst_q <= (state_d != ST_RUN);
            running_q  <= (state_d == ST_RUN);
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign done_mask   = mask_w;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// Scoreboard bench for multicore_run_ctrl.
// Random and directed runs checked against a loop-based run model.
module tb_multicore_run_ctrl;

    localparam int NC = 2;
    localparam int RC = 3;
    localparam int MC = 15;
    localparam int CW = 4;
    localparam logic [31:0] SA = 32'h0000_00FC;
    localparam logic [31:0] SD = 32'h0000_0001;

    typedef struct packed {
        logic          done;
        logic          to;
        logic [NC-1:0] mask;
        logic [CW-1:0] cc;
        logic [CW*NC-1:0] wr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NC-1:0]     mw;
    logic [32*NC-1:0]  adr_bus;
    logic [32*NC-1:0]  dat_bus;
    logic              core_rst;
    logic              running;
    logic              done;
    logic              timeout;
    logic [NC-1:0]     done_mask;
    logic [CW-1:0]     cycle_count;
    logic [CW*NC-1:0]  wr_count;

    logic [NC-1:0] s_mw  [MC];
    logic [31:0]   s_adr [MC][NC];
    logic [31:0]   s_dat [MC][NC];
    logic          s_st  [MC];

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    multicore_run_ctrl #(
        .NCORES     (NC),
        .RST_CYCLES (RC),
        .MAX_CYCLES (MC),
        .CNT_W      (CW),
        .STOP_ADDR  (SA),
        .STOP_DATA  (SD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .core_memwrite  (mw),
        .core_dataadr   (adr_bus),
        .core_writedata (dat_bus),
        .core_rst       (core_rst),
        .running        (running),
        .done           (done),
        .timeout        (timeout),
        .done_mask      (done_mask),
        .cycle_count    (cycle_count),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    function automatic exp_t model();
        exp_t e;
        int   cnt [NC];
        e = '0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        for (int c = 0; c < MC; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (s_mw[c][i]) begin
                    if (cnt[i] < (1 << CW) - 1) cnt[i]++;
                    if (s_adr[c][i] == SA && s_dat[c][i] == SD)
                        e.mask[i] = 1'b1;
                end
            end
            if (&e.mask) begin
                e.done = 1'b1;
                e.cc   = CW'(c + 1);
                break;
            end
            if (c == MC - 1) begin
                e.to = 1'b1;
                e.cc = CW'(MC);
            end
        end
        for (int i = 0; i < NC; i++) e.wr[CW*i +: CW] = CW'(cnt[i]);
        return e;
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MC; c++) begin
            s_mw[c] = '0;
            s_st[c] = 1'b0;
            for (int i = 0; i < NC; i++) begin
                s_adr[c][i] = 32'h0;
                s_dat[c][i] = 32'h0;
            end
        end
    endtask

    task automatic put_wr(input int c, input int i,
                          input logic [31:0] a, input logic [31:0] d);
        s_mw[c][i]  = 1'b1;
        s_adr[c][i] = a;
        s_dat[c][i] = d;
    endtask

    task automatic rand_stim(input int hit);
        int sel;
        clear_stim();
        for (int c = 0; c < MC; c++) begin
            for (int i = 0; i < NC; i++) begin
                s_mw[c][i] = 1'($urandom_range(0, 1));
                sel = int'($urandom_range(0, 99));
                if (sel < hit) begin
                    s_adr[c][i] = SA; s_dat[c][i] = SD;
                end else if (sel < 60) begin
                    s_adr[c][i] = SA; s_dat[c][i] = 32'h2;
                end else if (sel < 80) begin
                    s_adr[c][i] = 32'hF8; s_dat[c][i] = SD;
                end else begin
                    s_adr[c][i] = $urandom; s_dat[c][i] = $urandom;
                end
            end
        end
    endtask

    task automatic drive_idle();
        mw      = '0;
        adr_bus = '0;
        dat_bus = '0;
        start   = 1'b0;
    endtask

    task automatic begin_run();
        start = 1'b1;
        for (int k = 1; k <= RC; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("core_rst_held", 32'(core_rst), 32'd1);
        end
        @(negedge clk);
        chk("core_rst_released", 32'(core_rst), 32'd0);
        chk("running_set", 32'(running), 32'd1);
    endtask

    task automatic do_run();
        exp_t e;
        e = model();
        for (int c = 0; c < int'(e.cc); c++)
            if (e.done && $urandom_range(0, 5) == 0) s_st[c] = 1'b1;
        q.push_back(e);
        begin_run();
        for (int c = 0; c < MC; c++) begin
            mw    = s_mw[c];
            start = s_st[c];
            for (int i = 0; i < NC; i++) begin
                adr_bus[32*i +: 32] = s_adr[c][i];
                dat_bus[32*i +: 32] = s_dat[c][i];
            end
            @(negedge clk);
        end
        drive_idle();
        repeat (2) @(negedge clk);
        chk("result_seen", 32'(q.size()), 32'd0);
        chk("hold_done", 32'(done), 32'(e.done));
        chk("hold_timeout", 32'(timeout), 32'(e.to));
        chk("hold_mask", 32'(done_mask), 32'(e.mask));
        chk("hold_cycles", 32'(cycle_count), 32'(e.cc));
        chk("hold_wr", 32'(wr_count), 32'(e.wr));
        chk("frozen_rst", 32'(core_rst), 32'd1);
        chk("frozen_run", 32'(running), 32'd0);
        q.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_mask", 32'(done_mask), 32'd0);
        chk("rst_cycles", 32'(cycle_count), 32'd0);
        chk("rst_wr", 32'(wr_count), 32'd0);
    endtask

    // Monitor: compare each finished run against the queued expectation.
    initial begin : monitor
        logic fin_prev;
        exp_t e;
        fin_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((done | timeout) && !fin_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_end", 32'(done | timeout), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done", 32'(done), 32'(e.done));
                    chk("timeout", 32'(timeout), 32'(e.to));
                    chk("done_mask", 32'(done_mask), 32'(e.mask));
                    chk("cycle_count", 32'(cycle_count), 32'(e.cc));
                    chk("wr_count", 32'(wr_count), 32'(e.wr));
                end
            end
            fin_prev = done | timeout;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b1;
        @(negedge clk);

        clear_stim();
        do_run();

        clear_stim();
        put_wr(3, 0, SA, SD);
        put_wr(6, 1, SA, SD);
        do_run();

        clear_stim();
        put_wr(MC - 1, 0, SA, SD);
        put_wr(MC - 1, 1, SA, SD);
        do_run();

        clear_stim();
        put_wr(2, 0, SA, 32'h2);
        put_wr(5, 0, 32'hF8, SD);
        do_run();

        clear_stim();
        for (int c = 0; c < MC; c++) put_wr(c, 1, 32'h40, 32'h7);
        do_run();

        clear_stim();
        put_wr(1, 0, SA, SD);
        put_wr(3, 0, SA, SD);
        put_wr(8, 1, SA, SD);
        do_run();

        begin_run();
        repeat (4) @(negedge clk);
        mw = '1;
        adr_bus = {NC{SA}};
        dat_bus = {NC{SD}};
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        chk_reset_vals();
        @(negedge clk);
        chk_reset_vals();

        clear_stim();
        put_wr(3, 0, SA, SD);
        put_wr(6, 1, SA, SD);
        do_run();

        for (int r = 0; r < 20; r++) begin
            rand_stim(int'($urandom_range(2, 15)));
            do_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
